// File: rtl/prim_clk_gate.sv
// Integrated clock-gating cell: a low-transparent enable latch ANDed with the source clock.
// Swap this file for a technology ICG wrapper with identical ports when one is available.
module prim_clk_gate #(
    parameter bit NoFpgaGate    = 1'b0,
    parameter bit FpgaBufGlobal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    // Global-buffer selection only matters to the build flow.
    logic unused_fpga_buf_global;
    assign unused_fpga_buf_global = FpgaBufGlobal;

    if (NoFpgaGate) begin : gen_bypass
        logic unused_ctrl;
        assign unused_ctrl = en_i ^ test_en_i ^ rst_ni;
        assign clk_o       = clk_i;
    end else begin : gen_gate
        logic en_latch;

        // Enable is captured only while the clock is low, so a high phase is never cut short
        // by the enable; reset overrides the latch at any time.
        always_latch begin
            if (!rst_ni) begin
                en_latch = 1'b0;
            end else if (!clk_i) begin
                en_latch = en_i | test_en_i;
            end
        end

        assign clk_o = clk_i & en_latch;
    end

endmodule

// File: tb/tb_prim_clk_gate.sv
// Self-checking bench for prim_clk_gate: vector table with scoreboard plus hand-written
// glitch and async-reset sequences; a pulse-shape monitor watches every gated-clock edge.
module tb_prim_clk_gate;

    typedef struct {
        bit    rst_n;
        bit    en;
        bit    test_en;
        bit    exp_high;
        string name;
    } vec_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic en      = 1'b1;
    logic test_en = 1'b0;
    logic clk_gated;
    logic clk_byp;

    int   checks    = 0;
    int   errors    = 0;
    int   pulse_cnt = 0;
    int   cnt_snap;
    bit   expq[$];
    vec_t vecs[$];

    prim_clk_gate #(
        .NoFpgaGate    (1'b0),
        .FpgaBufGlobal (1'b1)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (en),
        .test_en_i (test_en),
        .clk_o     (clk_gated)
    );

    prim_clk_gate #(
        .NoFpgaGate    (1'b1),
        .FpgaBufGlobal (1'b1)
    ) byp (
        .clk_i     (clk),
        .rst_ni    (1'b0),
        .en_i      (1'b0),
        .test_en_i (1'b0),
        .clk_o     (clk_byp)
    );

    // Rising edges at 5+10k, falling edges at 10k.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Gated clock may only rise with clk, and only fall with clk or because of reset.
    always @(posedge clk_gated) begin
        pulse_cnt <= pulse_cnt + 1;
        check("chk_rise_aligned", ($time % 10) == 5, 1'b1);
    end

    always @(negedge clk_gated) begin
        check("chk_fall_aligned", (($time % 10) == 0) || !rst_n, 1'b1);
    end

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        #1;
        rst_n   = v.rst_n;
        en      = v.en;
        test_en = v.test_en;
        expq.push_back(v.exp_high);
        #1;
        check({v.name, "_low"}, clk_gated, 1'b0);
        check({v.name, "_byp_low"}, clk_byp, 1'b0);
    endtask

    task automatic checkOutput(input string name);
        bit exp;
        @(posedge clk);
        #2;
        if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", name);
        end else begin
            exp = expq.pop_front();
            check(name, clk_gated, exp);
        end
        check({name, "_byp_high"}, clk_byp, 1'b1);
    endtask

    function automatic vec_t mk(input bit r, input bit e, input bit t, input bit x, input string n);
        vec_t v;
        v.rst_n    = r;
        v.en       = e;
        v.test_en  = t;
        v.exp_high = x;
        v.name     = n;
        return v;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset hold with enable asserted, then release mid-low-phase.
        for (int i = 0; i < 10; i++) vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, "reset_hold"));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, "reset_release"));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name);
        end
        vecs.delete();

        // Enable gating: four cycles on, four off.
        cnt_snap = pulse_cnt;
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, "en_on"));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, "en_off"));
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name);
        end
        check("en_pulse_count_is_4", (pulse_cnt - cnt_snap) == 4, 1'b1);
        vecs.delete();

        // Test override, then release, then both enables together.
        cnt_snap = pulse_cnt;
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, "test_on"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, "test_off"));
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name);
        end
        check("test_pulse_count_is_5", (pulse_cnt - cnt_snap) == 5, 1'b1);
        vecs.delete();
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, "both_on"));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, "both_off"));
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name);
        end

        // Glitch immunity with the gate open: 1->0->1 inside a high phase.
        @(negedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        #1 check("glitch_open_a", clk_gated, 1'b1);
        #1 en = 1'b1;
        #1 check("glitch_open_b", clk_gated, 1'b1);
        en = 1'b0;
        @(posedge clk);
        #2 check("glitch_open_next_closed", clk_gated, 1'b0);

        // Glitch immunity with the gate closed: 0->1 inside a high phase.
        #1 en = 1'b1;
        #1 check("glitch_closed_a", clk_gated, 1'b0);
        #1 check("glitch_closed_b", clk_gated, 1'b0);
        @(posedge clk);
        #2 check("glitch_closed_next_open", clk_gated, 1'b1);

        // Async reset mid-pulse, released during a high phase.
        @(posedge clk);
        #2 check("arst_pre", clk_gated, 1'b1);
        rst_n = 1'b0;
        #1 check("arst_truncate", clk_gated, 1'b0);
        @(posedge clk);
        #2 check("arst_hold", clk_gated, 1'b0);
        rst_n = 1'b1;
        #1 check("arst_release_same_phase", clk_gated, 1'b0);
        @(posedge clk);
        #2 check("arst_first_pulse", clk_gated, 1'b1);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
